// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch initiator. Drives the word address into a
//                combinational instruction memory, buffers returned words
//                together with their byte PC in a small FIFO, and presents
//                {pc, instr} to decode over a valid/ready handshake. A
//                redirect reloads the PC and flushes the buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int          ADDR_W   = 13,
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [31:0]       instr_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_pc;
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [31:0]       r_fifo_pc   [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic [31:0]       w_redirect_pc;
  logic              w_unused_rpc_bits;

  // Byte offset of a redirect target is meaningless for word fetch.
  assign w_redirect_pc     = {redirect_pc[31:2], 2'b00};
  assign w_unused_rpc_bits = ^redirect_pc[1:0];

  assign imem_addr   = r_pc[ADDR_W+1:2];
  assign instr_valid = (r_count != '0);
  assign w_full      = (r_count == C_DEPTH);
  assign w_pop       = instr_valid & instr_ready;
  // Head fields read as zero when the buffer is empty.
  assign instr_data  = instr_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign instr_pc    = instr_valid ? r_fifo_pc[r_rd_ptr]   : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and push decision; a redirect always wins over a push, and a
  // full buffer only accepts a new word when the head leaves the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fetch_en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!fetch_en) w_state_nxt = S_IDLE;
        w_push = fetch_en & ~redirect_valid & (~w_full | w_pop);
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Program counter: redirect reloads it, each push advances one word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_pc;
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Buffer pointers and occupancy; a redirect discards everything left
  // after this cycle's pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage: the memory word is captured at the edge ending the push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_data;
      r_fifo_pc[r_wr_ptr]   <= r_pc;
    end
  end

endmodule
`default_nettype wire
